// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI mode-0 master.
package spi_pkg;

   localparam int unsigned SPI_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD
   } spi_state_e;

   // Ticks consumed by one transfer: CS setup, 2*W SCLK edges, CS hold.
   function automatic int unsigned spi_xfer_ticks(input int unsigned w);
      return 2 * w + 2;
   endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Combined tx/rx shift register: MSB drives the serial output, LSB takes the serial input.
module spi_shift_reg #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         sample_en,
   input  logic         sin,
   input  logic         shift_en,
   input  logic         clr,
   output logic [W-1:0] data,
   output logic         sout
);

   // Sampling shifts the word left, which exposes the next tx bit at the MSB
   // half an SCLK period before shift_en copies it to sout.
   always_ff @(posedge clk) begin
      if (rst) begin
         data <= '0;
         sout <= 1'b0;
      end else if (load) begin
         data <= load_data;
         sout <= load_data[W-1];
      end else begin
         if (sample_en) begin
            data <= {data[W-2:0], sin};
         end
         if (shift_en) begin
            sout <= data[W-1];
         end else if (clr) begin
            sout <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 master clocked by tick enables from the clock divider.
// Build option: define SPI_LOOPBACK_EN to receive from the internal mosi register instead of miso.
module spi_master_tx
   import spi_pkg::*;
#(
   parameter int unsigned DATA_W = SPI_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic              start,
   input  logic [DATA_W-1:0] tx_data,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] rx_data,
   output logic              sclk,
   output logic              mosi,
   input  logic              miso,
   output logic              cs_n
);

   localparam int unsigned CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   spi_state_e        state;
   spi_state_e        state_d;
   logic [CNT_W-1:0]  bit_cnt;
   logic [CNT_W-1:0]  bit_cnt_d;
   logic              sclk_d;
   logic              cs_n_d;
   logic              busy_d;
   logic              done_d;
   logic [DATA_W-1:0] rx_data_d;

   logic              load_c;
   logic              sample_c;
   logic              shift_c;
   logic              clr_c;
   logic              sin_c;
   logic [DATA_W-1:0] sr_data;

`ifdef SPI_LOOPBACK_EN
   logic unused_miso;
   assign unused_miso = miso;
   assign sin_c       = mosi;
`else
   assign sin_c       = miso;
`endif

   spi_shift_reg #(
      .W (DATA_W)
   ) u_shift_reg (
      .clk       (clk),
      .rst       (rst),
      .load      (load_c),
      .load_data (tx_data),
      .sample_en (sample_c),
      .sin       (sin_c),
      .shift_en  (shift_c),
      .clr       (clr_c),
      .data      (sr_data),
      .sout      (mosi)
   );

   // State and registered pin outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         bit_cnt <= '0;
         sclk    <= 1'b0;
         cs_n    <= 1'b1;
         busy    <= 1'b0;
         done    <= 1'b0;
         rx_data <= '0;
      end else begin
         state   <= state_d;
         bit_cnt <= bit_cnt_d;
         sclk    <= sclk_d;
         cs_n    <= cs_n_d;
         busy    <= busy_d;
         done    <= done_d;
         rx_data <= rx_data_d;
      end
   end

   // Next-state and output decode; start is refused while done is still high.
   always_comb begin
      state_d   = state;
      bit_cnt_d = bit_cnt;
      sclk_d    = sclk;
      cs_n_d    = cs_n;
      busy_d    = busy;
      done_d    = 1'b0;
      rx_data_d = rx_data;
      load_c    = 1'b0;
      sample_c  = 1'b0;
      shift_c   = 1'b0;
      clr_c     = 1'b0;

      case (state)
         IDLE: begin
            if (start && !done) begin
               load_c  = 1'b1;
               cs_n_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (tick) begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (tick) begin
               if (!sclk) begin
                  sclk_d   = 1'b1;
                  sample_c = 1'b1;
               end else begin
                  sclk_d = 1'b0;
                  if (bit_cnt == LAST_BIT) begin
                     state_d = HOLD;
                  end else begin
                     shift_c   = 1'b1;
                     bit_cnt_d = bit_cnt + CNT_W'(1);
                  end
               end
            end
         end
         HOLD: begin
            if (tick) begin
               cs_n_d    = 1'b1;
               rx_data_d = sr_data;
               done_d    = 1'b1;
               busy_d    = 1'b0;
               clr_c     = 1'b1;
               bit_cnt_d = '0;
               state_d   = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_spi_master_tx.sv
// Self-checking bench for spi_master_tx with a mode-0 slave model and randomized transfers.
module tb_spi_master_tx;

   localparam int unsigned W     = 8;
   localparam int          TICKS = 2 * W + 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         tick;
   logic         start;
   logic [W-1:0] tx_data;
   logic         miso;
   logic         busy;
   logic         done;
   logic [W-1:0] rx_data;
   logic         sclk;
   logic         mosi;
   logic         cs_n;

   int checks   = 0;
   int failures = 0;

   logic         sclk_prev  = 1'b0;
   logic         mosi_prev  = 1'b0;
   logic         cs_n_prev  = 1'b1;
   int           rises      = 0;
   int           violations = 0;
   int           done_cnt   = 0;
   logic [W-1:0] cap_word   = '0;
   logic [W-1:0] slave_word = '0;

   spi_master_tx #(.DATA_W(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .start   (start),
      .tx_data (tx_data),
      .busy    (busy),
      .done    (done),
      .rx_data (rx_data),
      .sclk    (sclk),
      .mosi    (mosi),
      .miso    (miso),
      .cs_n    (cs_n)
   );

   always #5 clk = ~clk;

   // Slave model and pin monitor: captures mosi at each SCLK rise, presents the next miso bit.
   task automatic observe();
      if (sclk === 1'b1 && sclk_prev === 1'b0) begin
         cap_word = {cap_word[W-2:0], mosi};
         rises++;
      end
      if (mosi !== mosi_prev && !(sclk_prev === 1'b1 && sclk === 1'b0) && cs_n === cs_n_prev)
         violations++;
      if (done === 1'b1) done_cnt++;
      sclk_prev = sclk;
      mosi_prev = mosi;
      cs_n_prev = cs_n;
      miso = (rises < int'(W)) ? slave_word[int'(W) - 1 - rises] : 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      observe();
   endtask

   task automatic do_transfer(input logic [W-1:0] tx, input logic [W-1:0] slv, input int period,
                              input bit mid_start, input bit chain, input logic [W-1:0] next_tx,
                              input string name);
      logic [W-1:0] exp_rx;
      int           nticks;
      bit           got_done;
      bit           done_on_last;
`ifdef SPI_LOOPBACK_EN
      exp_rx = tx;
`else
      exp_rx = slv;
`endif
      nticks = 0; got_done = 0; done_on_last = 0;
      slave_word = slv; rises = 0; cap_word = '0; violations = 0; done_cnt = 0;
      miso = slv[W-1];
      tx_data = tx; start = 1'b1; tick = 1'b1;
      step();
      start = 1'b0; tick = 1'b0;
      checks++;
      if (busy !== 1'b1 || cs_n !== 1'b0 || sclk !== 1'b0 || mosi !== tx[W-1]) begin
         failures++;
         $display("FAIL %s accept busy=%b cs_n=%b sclk=%b mosi=%b exp 1 0 0 %b",
                  name, busy, cs_n, sclk, mosi, tx[W-1]);
      end
      tx_data = ~tx;
      for (int cyc = 1; cyc <= (TICKS + 4) * period + 10; cyc++) begin
         tick  = (cyc % period == 0);
         start = mid_start && (cyc == 5 * period + 1);
         step();
         if (tick) nticks++;
         if (done === 1'b1) begin
            got_done     = 1;
            done_on_last = tick && (nticks == TICKS);
            break;
         end
      end
      start = 1'b0; tick = 1'b0;
      checks++;
      if (!got_done || !done_on_last) begin
         failures++;
         $display("FAIL %s done_timing got_done=%0d ticks=%0d exp done right after tick %0d",
                  name, got_done, nticks, TICKS);
      end
      checks++;
      if (rx_data !== exp_rx) begin
         failures++;
         $display("FAIL %s rx_data got=%h exp=%h", name, rx_data, exp_rx);
      end
      checks++;
      if (rises != int'(W) || cap_word !== tx) begin
         failures++;
         $display("FAIL %s mosi_at_rise rises=%0d word=%h exp rises=%0d word=%h",
                  name, rises, cap_word, W, tx);
      end
      checks++;
      if (violations != 0) begin
         failures++;
         $display("FAIL %s mosi_change_off_fall count=%0d exp 0", name, violations);
      end
      checks++;
      if (busy !== 1'b0 || cs_n !== 1'b1 || sclk !== 1'b0 || mosi !== 1'b0) begin
         failures++;
         $display("FAIL %s end_pins busy=%b cs_n=%b sclk=%b mosi=%b exp 0 1 0 0",
                  name, busy, cs_n, sclk, mosi);
      end
      if (chain) begin
         start = 1'b1; tx_data = next_tx;
         step();
         checks++;
         if (busy !== 1'b0 || cs_n !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL %s start_in_done busy=%b cs_n=%b done=%b exp 0 1 0",
                     name, busy, cs_n, done);
         end
      end else begin
         for (int cyc = 1; cyc <= 6 * period; cyc++) begin
            tick = (cyc % period == 0);
            step();
         end
         tick = 1'b0;
         checks++;
         if (done_cnt != 1 || cs_n !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s single_transfer dones=%0d cs_n=%b busy=%b exp 1 1 0",
                     name, done_cnt, cs_n, busy);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; tick = 1'b0; tx_data = '0; miso = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      checks++;
      if (sclk !== 1'b0 || cs_n !== 1'b1 || mosi !== 1'b0) begin
         failures++;
         $display("FAIL reset_pins sclk=%b cs_n=%b mosi=%b exp 0 1 0", sclk, cs_n, mosi);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || rx_data !== '0) begin
         failures++;
         $display("FAIL reset_status busy=%b done=%b rx=%h exp 0 0 00", busy, done, rx_data);
      end
      for (int i = 0; i < 40; i++) begin
         tick = (i % 4 == 3);
         step();
         checks++;
         if (sclk !== 1'b0 || cs_n !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL idle_tick cyc=%0d sclk=%b cs_n=%b busy=%b done=%b exp 0 1 0 0",
                     i, sclk, cs_n, busy, done);
         end
      end
      tick = 1'b0;
   endtask

   task automatic test_basic();
      do_transfer(8'hA5, 8'h3C, 50, 1'b0, 1'b0, 8'h00, "basic");
   endtask

   task automatic test_busy_reject();
      do_transfer(8'hFF, W'($urandom), 10, 1'b1, 1'b0, 8'h00, "busy_reject");
   endtask

   task automatic test_back_to_back();
      do_transfer(8'h7E, 8'h99, 4, 1'b0, 1'b1, 8'h81, "b2b_first");
      do_transfer(8'h81, 8'h66, 4, 1'b0, 1'b0, 8'h00, "b2b_second");
   endtask

   task automatic test_reset_mid();
      int nticks;
      nticks = 0;
      slave_word = 8'hF0; rises = 0; miso = 1'b1;
      tx_data = 8'h96; start = 1'b1;
      step();
      start = 1'b0;
      for (int cyc = 1; cyc <= 100 && nticks < 5; cyc++) begin
         tick = (cyc % 4 == 0);
         step();
         if (tick) nticks++;
      end
      tick = 1'b0; rst = 1'b1;
      step();
      rst = 1'b0;
      checks++;
      if (sclk !== 1'b0 || cs_n !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || rx_data !== '0) begin
         failures++;
         $display("FAIL reset_mid sclk=%b cs_n=%b busy=%b done=%b rx=%h exp 0 1 0 0 00",
                  sclk, cs_n, busy, done, rx_data);
      end
      done_cnt = 0;
      for (int cyc = 1; cyc <= 80; cyc++) begin
         tick = (cyc % 4 == 0);
         step();
      end
      tick = 1'b0;
      checks++;
      if (done_cnt != 0 || cs_n !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_quiet dones=%0d cs_n=%b exp 0 1", done_cnt, cs_n);
      end
      do_transfer(8'h5A, 8'hC7, 6, 1'b0, 1'b0, 8'h00, "after_reset");
   endtask

   task automatic test_random();
      for (int i = 0; i < 6; i++) begin
         do_transfer(W'($urandom), W'($urandom), int'($urandom_range(1, 6)),
                     1'($urandom_range(0, 1)), 1'b0, 8'h00, "random");
      end
   endtask

`ifdef SPI_LOOPBACK_EN
   task automatic test_loopback();
      do_transfer(8'hC3, 8'h00, 5, 1'b0, 1'b0, 8'h00, "loopback");
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_busy_reject();
      test_back_to_back();
      test_reset_mid();
      test_random();
`ifdef SPI_LOOPBACK_EN
      test_loopback();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
- SPI mode-0 master. Sits directly downstream of the team's clock divider.
- Runs entirely on the system clock. The divider stage supplies `tick`, a one-cycle enable pulse, at the SCLK half-period rate.
- Shifts one DATA_W-bit word out on MOSI, MSB first, and captures one word from MISO in the same transfer.
- Reports completion with a `done` pulse.

Parameters:
- DATA_W, 8, transfer word width in bits; must be >= 2.

Ports:
- clk  input  1  system clock (100 MHz).
- rst  input  1  synchronous, active-high reset.
- tick  input  1  one-cycle enable; each pulse marks one SCLK half-period.
- start  input  1  request a transfer; sampled every clk.
- tx_data  input  DATA_W  word to send; latched on start acceptance.
- busy  output  1  high from the cycle after start acceptance until the done cycle.
- done  output  1  one-clk pulse when the transfer completes.
- rx_data  output  DATA_W  last received word; updated in the done cycle.
- sclk  output  1  SPI clock; idles low (CPOL=0).
- mosi  output  1  serial data out; changes on SCLK falling edges.
- miso  input  1  serial data in; sampled on SCLK rising edges.
- cs_n  output  1  active-low chip select.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: sclk=0, cs_n=1, mosi=0, busy=0, done=0, rx_data=0, bit counter=0, state=IDLE.
- Bit counter width is $clog2(DATA_W).
- Only rst, start in IDLE, and ticks in non-IDLE states change state.
- IDLE:
  - start=1 is accepted.
  - Latch tx_data into the shift register. Drive mosi=tx_data[DATA_W-1] and cs_n=0 on the next edge; busy=1.
  - Go to SETUP.
  - A tick in the same cycle as start is ignored.
- SETUP: next tick -> SHIFT with sclk unchanged at 0. This gives one half-period of CS-to-SCLK setup.
- SHIFT: each tick toggles sclk.
  - On a 0->1 toggle: sample miso into the LSB of the rx shift register (shift left).
  - On a 1->0 toggle with bit_cnt==DATA_W-1: go to HOLD. mosi holds its value.
  - On a 1->0 toggle otherwise: shift out the next tx bit on mosi and increment bit_cnt.
- HOLD: next tick:
  - cs_n=1, rx_data <= rx shift register, done=1 for exactly one clk, busy=0, mosi=0, bit_cnt=0.
  - Go to IDLE.
- Transfer length: exactly 2*DATA_W+2 ticks from acceptance to done (18 ticks for DATA_W=8).
- start while busy=1 is ignored, including in the done cycle. A new start is accepted at the earliest one clk after done.
- Ticks while IDLE have no effect.
- rst mid-transfer: within one clk, sclk=0, cs_n=1, busy=0, no done pulse, rx_data cleared to 0.
- tx_data changes after acceptance do not affect the transfer in progress.

Optional Feature:
- Macro: SPI_LOOPBACK_EN.
- Defined: the receive path samples the internal mosi register instead of the miso port. rx_data therefore equals tx_data after every transfer; the miso port is unused.
- Undefined: miso is sampled normally.
- Pin behaviour (sclk, mosi, cs_n) is identical in both builds.

Decomposition:
- Shared package spi_pkg holds:
  - the state typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD};
  - the default data width constant SPI_DATA_W=8.
- One natural sub-module, spi_shift_reg:
  - parallel load, shift-out MSB on a shift enable, shift-in LSB on a sample enable, parallel read.
  - Instantiated once for the combined tx/rx register.

Test Plan:
- Reset/idle: hold rst 3 clks, then tick every 4 clks with no start -> sclk=0, cs_n=1, busy=0, done never asserts.
- Basic transfer: tx_data=8'hA5, miso slave model returns 8'h3C; tick every 50 clks:
  - mosi bits 1,0,1,0,0,1,0,1 are stable at each sclk rise;
  - exactly 8 sclk rising edges;
  - done one clk after the 18th tick; rx_data=8'h3C; cs_n high after done.
- Busy rejection: start with 8'hFF, pulse start again with 8'h00 mid-transfer -> ignored; only one transfer occurs; mosi stays 1 for all 8 bits.
- Back-to-back: assert start the clk after done with 8'h81 following 8'h7E -> second transfer accepted; cs_n high for at least one clk between transfers; both rx words are correct.
- Reset mid-transfer: rst after the 5th tick -> next clk sclk=0, cs_n=1, busy=0, rx_data=0, no done; a subsequent 8'h5A transfer is clean.
- With SPI_LOOPBACK_EN defined and miso tied 0: tx_data=8'hC3 -> rx_data=8'hC3.
